// File: rtl/axi4lite_master_cmd_if.sv
// axi4lite_if: AXI4-Lite signal bundle shared by an initiator and a target.
//   master modport: drives AW/W/AR channels and BREADY/RREADY, samples the rest.
//   slave  modport: the mirror image.
interface axi4lite_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] AWADDR;
  logic                  AWVALID;
  logic                  AWREADY;
  logic [DATA_WIDTH-1:0] WDATA;
  logic [STRB_WIDTH-1:0] WSTRB;
  logic                  WVALID;
  logic                  WREADY;
  logic [1:0]            BRESP;
  logic                  BVALID;
  logic                  BREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic                  ARVALID;
  logic                  ARREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [1:0]            RRESP;
  logic                  RVALID;
  logic                  RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi4lite_master_cmd.sv
// axi4lite_master_cmd: single-outstanding AXI4-Lite initiator.
//   CLK, RST           : clock, synchronous active-high reset
//   cmd_*              : command in (valid/ready, write flag, addr, wdata, wstrb)
//   rsp_*              : held response out (valid/ready, write flag, rdata, resp)
//   axi_master         : AXI4-Lite initiator port
// Every output, AXI and response alike, comes straight from a register.
module axi4lite_master_cmd #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi4lite_if.master              axi_master
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                r_state;
  logic                  r_cmd_ready;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_rsp_valid;
  logic                  r_rsp_write;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]            r_rsp_resp;

  // A write channel is finished once its VALID is already down or is being accepted now;
  // the VALID registers double as the per-channel pending flags.
  logic w_aw_done;
  logic w_w_done;
  assign w_aw_done = !r_awvalid || axi_master.AWREADY;
  assign w_w_done  = !r_wvalid  || axi_master.WREADY;

  // Output drive, registers only
  assign cmd_ready          = r_cmd_ready;
  assign rsp_valid          = r_rsp_valid;
  assign rsp_write          = r_rsp_write;
  assign rsp_rdata          = r_rsp_rdata;
  assign rsp_resp           = r_rsp_resp;
  assign axi_master.AWADDR  = r_addr;
  assign axi_master.AWVALID = r_awvalid;
  assign axi_master.WDATA   = r_wdata;
  assign axi_master.WSTRB   = r_wstrb;
  assign axi_master.WVALID  = r_wvalid;
  assign axi_master.BREADY  = r_bready;
  assign axi_master.ARADDR  = r_addr;
  assign axi_master.ARVALID = r_arvalid;
  assign axi_master.RREADY  = r_rready;

  // Transaction sequencer
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= IDLE;
      r_cmd_ready <= 1'b1;
      r_write     <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_addr      <= cmd_addr;
            r_wdata     <= cmd_wdata;
            r_wstrb     <= cmd_wstrb;
            r_write     <= cmd_write;
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end

        WR_REQ: begin
          if (axi_master.AWREADY) r_awvalid <= 1'b0;
          if (axi_master.WREADY)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end

        WR_RESP: begin
          if (axi_master.BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_resp  <= axi_master.BRESP;
            r_rsp_rdata <= '0;
            r_rsp_write <= r_write;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end

        RD_REQ: begin
          if (axi_master.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_DATA;
          end
        end

        RD_DATA: begin
          if (axi_master.RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_rdata <= axi_master.RDATA;
            r_rsp_resp  <= axi_master.RRESP;
            r_rsp_write <= r_write;
            r_rsp_valid <= 1'b1;
            r_state     <= RSP;
          end
        end

        RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end

        default: begin
          r_state     <= IDLE;
          r_cmd_ready <= 1'b1;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_axi4lite_master_cmd.sv
// Bench for axi4lite_master_cmd: behavioural AXI4-Lite memory target with
// programmable READY delays, a reference memory model, and a response scoreboard.
module tb_axi4lite_master_cmd;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [5:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;

  axi4lite_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) bus ();

  axi4lite_master_cmd #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) dut (
    .CLK(clk), .RST(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .axi_master(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- response-ready control ----------------
  logic rsp_mode = 1'b0;
  logic rsp_man  = 1'b1;
  logic rsp_rnd  = 1'b1;
  always @(posedge clk) rsp_rnd <= 1'($urandom_range(0, 1));
  assign rsp_ready = rsp_mode ? rsp_rnd : rsp_man;

  // ---------------- AXI4-Lite memory target ----------------
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  slv_resp = 2'b00;
  int          aw_cnt, w_cnt, ar_cnt;
  logic        aw_got, w_got;
  logic [5:0]  aw_l;
  logic [31:0] wd_l;
  logic [3:0]  ws_l;
  logic        s_bvalid, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata;
  logic [31:0] smem [16];

  logic        aw_hs, w_hs, ar_hs, wr_fire;
  logic [5:0]  m_wa;
  logic [31:0] m_wd;
  logic [3:0]  m_ws;

  assign bus.AWREADY = bus.AWVALID && (aw_cnt >= aw_dly);
  assign bus.WREADY  = bus.WVALID  && (w_cnt  >= w_dly);
  assign bus.ARREADY = bus.ARVALID && (ar_cnt >= ar_dly);
  assign bus.BVALID  = s_bvalid;
  assign bus.BRESP   = s_bresp;
  assign bus.RVALID  = s_rvalid;
  assign bus.RDATA   = s_rdata;
  assign bus.RRESP   = s_rresp;

  assign aw_hs   = bus.AWVALID && bus.AWREADY;
  assign w_hs    = bus.WVALID && bus.WREADY;
  assign ar_hs   = bus.ARVALID && bus.ARREADY;
  assign wr_fire = (aw_got || aw_hs) && (w_got || w_hs) && !s_bvalid;
  assign m_wa    = aw_hs ? bus.AWADDR : aw_l;
  assign m_wd    = w_hs ? bus.WDATA : wd_l;
  assign m_ws    = w_hs ? bus.WSTRB : ws_l;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      aw_l <= '0; wd_l <= '0; ws_l <= '0;
      s_bvalid <= 1'b0; s_rvalid <= 1'b0;
      s_bresp <= 2'b00; s_rresp <= 2'b00; s_rdata <= '0;
      for (int i = 0; i < 16; i++) smem[i] <= '0;
    end else begin
      aw_cnt <= (bus.AWVALID && !bus.AWREADY) ? aw_cnt + 1 : 0;
      w_cnt  <= (bus.WVALID  && !bus.WREADY)  ? w_cnt + 1  : 0;
      ar_cnt <= (bus.ARVALID && !bus.ARREADY) ? ar_cnt + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; aw_l <= bus.AWADDR; end
      if (w_hs)  begin w_got <= 1'b1; wd_l <= bus.WDATA; ws_l <= bus.WSTRB; end
      if (wr_fire) begin
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
        s_bvalid <= 1'b1;
        s_bresp  <= slv_resp;
        if (slv_resp == 2'b00)
          for (int b = 0; b < 4; b++)
            if (m_ws[b]) smem[m_wa[5:2]][8*b +: 8] <= m_wd[8*b +: 8];
      end
      if (s_bvalid && bus.BREADY) s_bvalid <= 1'b0;
      if (ar_hs) begin
        s_rvalid <= 1'b1;
        s_rdata  <= smem[bus.ARADDR[5:2]];
        s_rresp  <= slv_resp;
      end
      if (s_rvalid && bus.RREADY) s_rvalid <= 1'b0;
    end
  end

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t        sbq [$];
  exp_t        mon_e;
  logic [31:0] exp_mem [16];
  int          last_hs = 0;
  logic [31:0] last_rdata = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endtask

  // Monitor: every consumed response is compared with the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_rsp: got write=%0b resp=%0d want no response", rsp_write, rsp_resp);
      end else begin
        mon_e = sbq.pop_front();
        check("rsp_write", 32'(rsp_write), 32'(mon_e.w));
        check("rsp_rdata", rsp_rdata, mon_e.d);
        check("rsp_resp", 32'(rsp_resp), 32'(mon_e.r));
        if (mon_e.lat) check("latency", 32'(cyc + 1 - mon_e.acc), 32'd3);
        last_hs    = cyc + 1;
        last_rdata = rsp_rdata;
      end
    end
  end

  // Issue one command; target behaviour for it is set once the DUT is idle.
  task automatic cmd(input logic w, input logic [5:0] a, input logic [31:0] d,
                     input logic [3:0] s, input logic [1:0] resp,
                     input int awd, input int wd, input int ard,
                     input bit lat, input bit b2b);
    int   t;
    exp_t e;
    t = 0;
    while (!cmd_ready && t < 300) begin @(posedge clk); #1; t++; end
    if (!cmd_ready) begin
      total++; bad++;
      $display("FAIL cmd_wait: cmd_ready got 0 want 1");
      return;
    end
    aw_dly = awd; w_dly = wd; ar_dly = ard; slv_resp = resp;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    if (b2b) check("b2b_accept", 32'(cyc), 32'(last_hs + 1));
    e.w = w; e.r = resp; e.acc = cyc; e.lat = lat;
    if (w) begin
      e.d = '0;
      if (resp == 2'b00)
        for (int b = 0; b < 4; b++)
          if (s[b]) exp_mem[a[5:2]][8*b +: 8] = d[8*b +: 8];
    end else begin
      e.d = exp_mem[a[5:2]];
    end
    sbq.push_back(e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sbq.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL drain: pending got %0d want 0", sbq.size());
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int awc, wc, stab_err, early_b, seen, extra;
    logic [1:0] rr;
    int sel;

    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_valids", 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
    check("rst_readies", 32'({bus.BREADY, bus.RREADY}), 32'd0);
    check("rst_rsp_fields", {rsp_rdata[29:0], rsp_resp}, 32'd0);
    check("rst_rsp_write", 32'(rsp_write), 32'd0);

    // Zero-wait write then read back, minimum latency
    cmd(1'b1, 6'h04, 32'hDEADBEEF, 4'hF, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    cmd(1'b0, 6'h04, 32'h0, 4'h0, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    drain();
    check("rd_deadbeef", last_rdata, 32'hDEADBEEF);

    // Byte-strobed partial write
    cmd(1'b1, 6'h08, 32'h11223344, 4'hF, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    cmd(1'b1, 6'h08, 32'hAABBCCDD, 4'b0011, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    cmd(1'b0, 6'h08, 32'h0, 4'h0, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    drain();
    check("rd_partial", last_rdata, 32'h1122CCDD);

    // AWREADY delayed 3 cycles, WREADY immediate
    cmd(1'b1, 6'h10, 32'hCAFEF00D, 4'hF, 2'b00, 3, 0, 0, 1'b0, 1'b0);
    awc = 0; wc = 0; stab_err = 0; early_b = 0; seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (bus.AWVALID) begin awc++; if (bus.AWADDR !== 6'h10) stab_err++; end
      if (bus.WVALID) begin
        wc++;
        if (bus.WDATA !== 32'hCAFEF00D || bus.WSTRB !== 4'hF) stab_err++;
      end
      if (bus.BREADY && bus.AWVALID) early_b++;
      if (rsp_valid) seen = 1;
    end
    check("aw_valid_cycles", 32'(awc), 32'd4);
    check("w_valid_cycles", 32'(wc), 32'd1);
    check("aw_w_stable", 32'(stab_err), 32'd0);
    check("bready_after_aw", 32'(early_b), 32'd0);
    check("delayed_rsp_seen", 32'(seen), 32'd1);
    drain();

    // SLVERR read held while rsp_ready is low; pulsed cmd_valid must be ignored
    cmd(1'b1, 6'h0C, 32'h5A5A5A5A, 4'hF, 2'b00, 0, 0, 0, 1'b0, 1'b0);
    drain();
    rsp_man = 1'b0;
    cmd(1'b0, 6'h0C, 32'h0, 4'h0, 2'b10, 0, 0, 0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    check("hold_rsp_seen", 32'(seen), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_resp", 32'(rsp_resp), 32'd2);
      check("hold_rdata", rsp_rdata, 32'h5A5A5A5A);
      check("hold_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clk); #1;
      cmd_valid = (i == 1); cmd_write = 1'b1; cmd_addr = 6'h20;
    end
    cmd_valid = 1'b0;
    rsp_man = 1'b1;
    drain();
    extra = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.AWVALID || bus.ARVALID || !cmd_ready) extra++;
    end
    check("busy_cmd_ignored", 32'(extra), 32'd0);

    // Reset during WR_REQ with AWREADY held low
    cmd(1'b1, 6'h14, 32'h12345678, 4'hF, 2'b00, 10, 0, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sbq.delete();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    check("mid_rst_valids", 32'({bus.AWVALID, bus.WVALID, bus.ARVALID}), 32'd0);
    check("mid_rst_readies", 32'({bus.BREADY, bus.RREADY}), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    cmd(1'b0, 6'h00, 32'h0, 4'h0, 2'b00, 0, 0, 0, 1'b1, 1'b0);
    drain();

    // Back-to-back alternating write/read over the whole address map
    for (int i = 0; i < 16; i++) begin
      cmd(1'b1, 6'(i * 4), $urandom, 4'hF, 2'b00, 0, 0, 0, 1'b1, (i != 0));
      cmd(1'b0, 6'(i * 4), 32'h0, 4'h0, 2'b00, 0, 0, 0, 1'b1, 1'b1);
    end
    drain();

    // Randomised traffic: delays, strobes, response codes, response backpressure
    rsp_mode = 1'b1;
    for (int i = 0; i < 80; i++) begin
      sel = $urandom_range(0, 5);
      rr  = (sel == 0) ? 2'b10 : (sel == 1) ? 2'b11 : 2'b00;
      cmd(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), $urandom,
          4'($urandom_range(0, 15)), rr,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, 1'b0);
    end
    drain();
    rsp_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/axi4lite_master_cmd.md
# axi4lite_master_cmd

AXI4-Lite initiator that converts a simple single-beat command/response interface into AXI4-Lite read and write transactions on an `axi4lite_if.master` port. It is the opposite end of the team's AXI4-Lite slave memory. Test controllers and on-chip sequencers use it to access any AXI4-Lite slave. Exactly one transaction is outstanding at a time; completion status and read data return through a held response channel.

## Interface
- `ADDR_WIDTH`, 6, byte address width of `AWADDR`, `ARADDR` and `cmd_addr`.
- `DATA_WIDTH`, 32, data width; strobe width is `DATA_WIDTH/8`.
- `CLK`  in  1  single clock for all logic.
- `RST`  in  1  reset, synchronous, active-high, sampled on `CLK` rising edge.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a rising edge.
- `cmd_write`  in  1  1 = write, 0 = read.
- `cmd_addr`  in  ADDR_WIDTH  transaction address.
- `cmd_wdata`  in  DATA_WIDTH  write data; ignored for reads.
- `cmd_wstrb`  in  DATA_WIDTH/8  write byte strobes; ignored for reads.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed when `rsp_valid && rsp_ready`.
- `rsp_write`  out  1  response belongs to a write (1) or a read (0).
- `rsp_rdata`  out  DATA_WIDTH  captured `RDATA`; 0 for writes.
- `rsp_resp`  out  2  captured `BRESP` or `RRESP`.
- `axi_master`  modport  —  `axi4lite_if.master`. Drives `AWADDR/AWVALID`, `WDATA/WSTRB/WVALID`, `BREADY`, `ARADDR/ARVALID`, `RREADY`. Samples `AWREADY`, `WREADY`, `BVALID/BRESP`, `ARREADY`, `RVALID/RDATA/RRESP`.

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: `cmd_ready`=1. On command accept, latch addr/wdata/wstrb/write into registers. Go to WR_REQ (write) or RD_REQ (read).
- WR_REQ: `AWVALID` and `WVALID` are asserted together on entry and tracked by independent pending flags.
  - Each VALID drops on the edge where its own READY is sampled high.
  - Go to WR_RESP once both handshakes are complete, including when both complete in the same cycle.
  - `AWADDR`/`WDATA`/`WSTRB` are held stable while the matching VALID is high.
- WR_RESP: `BREADY`=1. On `BVALID`, capture `BRESP`, set `rsp_rdata`=0 and `rsp_write`=1, then go to RSP.
- RD_REQ: `ARVALID`=1 with `ARADDR` stable. On `ARREADY`, drop `ARVALID` and go to RD_DATA.
- RD_DATA: `RREADY`=1. On `RVALID`, capture `RDATA`/`RRESP`, set `rsp_write`=0, then go to RSP.
- RSP: `rsp_valid`=1. Response fields stay stable until `rsp_ready`, then return to IDLE. `cmd_ready`=0 in every state except IDLE.
- No VALID is ever withdrawn before its handshake completes (AXI rule).
- All AXI outputs and all response outputs are driven directly from registers. There is no combinational path from any input to any output.
- Response codes are passed through unmodified: 00 OKAY, 10 SLVERR, 11 DECERR.

## Timing
- Reset (`RST`=1 at an edge): state=IDLE; all VALIDs, `BREADY`, `RREADY`, `rsp_valid`=0; `rsp_rdata`, `rsp_resp`, `rsp_write`, address and data registers=0. `cmd_ready` reads 1 from the first cycle after reset is released.
- Reset asserted mid-transaction aborts immediately; the in-flight transaction is lost. The system resets the slave in the same window.
- Command accepted at edge N: AXI VALID(s) are high from cycle N+1.
- Write with zero-wait slave: AW/W handshake at edge N+1; `BREADY` high in cycle N+2; `BVALID` at N+2 gives `rsp_valid` in N+3.
  - Minimum write latency: command accept to `rsp_valid` = 3 cycles.
- Read with zero-wait slave: `ARVALID` N+1; `RREADY` N+2; `RVALID` at N+2 gives `rsp_valid` in N+3.
  - Minimum read latency: 3 cycles.
- `rsp_valid && rsp_ready` at edge M: `cmd_ready`=1 in M+1. The next command is accepted at edge M+1 at the earliest.
- `cmd_valid` during a busy period is ignored; it is not queued.

## Test plan
- Write `cmd_addr`=0x04, wdata=0xDEADBEEF, wstrb=4'hF, to a zero-wait slave memory; then read 0x04 -> write `rsp_resp`=00 after 3 cycles; read `rsp_rdata`=0xDEADBEEF, `rsp_write`=0.
- Preload 0x08 with 0x11223344; write 0xAABBCCDD with wstrb=4'b0011; read 0x08 -> `rsp_rdata`=0x1122CCDD.
- `WREADY` immediate, `AWREADY` delayed 3 cycles -> `WVALID` high exactly 1 cycle, `AWVALID` high 4 cycles, `BREADY` rises only after the AW handshake, AWADDR/WDATA stable throughout.
- Slave returns `RRESP`=10 with `RDATA`=0x5A5A5A5A and `rsp_ready` is held low for 5 cycles -> `rsp_valid` and `rsp_resp`=10 / `rsp_rdata` held stable for 5 cycles, `cmd_ready`=0 and a pulsed `cmd_valid` is ignored.
- Assert `RST` for 1 cycle while in WR_REQ with `AWREADY` low -> next cycle all VALIDs, `BREADY`, `RREADY`, `rsp_valid`=0, `cmd_ready`=1; a following read of 0x00 completes normally.
- Back-to-back: 16 alternating writes and reads to addresses 0x00–0x3C with `rsp_ready` tied high -> every read returns the last written value and each command is accepted 1 cycle after the previous response.
